hdmi_scanout_fetch: RTL
=======================

Name: hdmi_scanout_fetch

Overview:
Scanout read scheduler for the HDMI controller's frame-buffer fetch path. It sequences AXI read-address bursts over one frame buffer per frame-start event. Bursts are throttled by a credit count that mirrors free space in the downstream pixel FIFO, and by a cap on outstanding bursts. The block owns the AR channel and RREADY; read data itself bypasses it into the pixel FIFO.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 512, AXI data width; bytes per beat = C_M_AXI_DATA_WIDTH/8
BURST_LEN, 16, beats per burst (1..256); ARLEN = BURST_LEN-1
MAX_OUTSTANDING, 4, maximum bursts issued but not completed (1..15)
FIFO_DEPTH, 256, pixel FIFO depth in beats (>= BURST_LEN)

Ports:
ACLK  in  1  clock
RST  in  1  synchronous reset, active-high
EN  in  1  fetch enable
FRAME_START  in  1  single-cycle pulse at frame start (from the timing generator)
BASE_ADDR  in  C_M_AXI_ADDR_WIDTH  frame-buffer base address; bits below log2(BURST_LEN*bytes/beat) are ignored
FRAME_BURSTS  in  16  number of bursts per frame
FIFO_POP  in  1  one beat consumed from the pixel FIFO
M_ARADDR  out  C_M_AXI_ADDR_WIDTH  burst address
M_ARLEN  out  8  constant BURST_LEN-1
M_ARVALID  out  1  address valid
M_ARREADY  in  1  address accepted
M_RVALID  in  1  read beat valid
M_RLAST  in  1  last beat of a burst
M_RREADY  out  1  read ready
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse: frame fetch finished
OVERRUN  out  1  sticky: FRAME_START arrived while BUSY
PERF_STALL  out  32  stall-cycle count (optional feature)

Behaviour:
- Reset values: M_ARVALID=0, M_ARADDR=0, M_RREADY=0, BUSY=0, DONE=0, OVERRUN=0, PERF_STALL=0. Internal: credit=FIFO_DEPTH, outstanding=0, remaining=0, state=IDLE. A reset mid-frame abandons the frame immediately.
- States: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE when FRAME_START & EN & FRAME_BURSTS!=0.
  - Latch aligned BASE_ADDR into the address register.
  - Latch FRAME_BURSTS into remaining.
  - Clear OVERRUN.
- FRAME_START with FRAME_BURSTS==0 in IDLE: no state change; DONE pulses the next cycle.
- ISSUE:
  - Issue condition: credit >= BURST_LEN and outstanding < MAX_OUTSTANDING and remaining != 0 and EN. M_ARVALID rises the cycle after the condition holds (registered).
  - Once M_ARVALID=1, it and M_ARADDR stay stable until M_ARREADY, regardless of EN or credit.
  - On handshake: address += BURST_LEN*bytes/beat (wraps modulo 2^C_M_AXI_ADDR_WIDTH); remaining--; credit -= BURST_LEN; outstanding++.
  - M_ARVALID may stay high back-to-back if the condition still holds after the update.
- ISSUE -> DRAIN when remaining reaches 0 at a handshake, or when EN=0 and M_ARVALID=0 (abort: no further bursts).
- DRAIN -> IDLE when outstanding==0; DONE=1 for exactly that transition cycle.
- M_RREADY = BUSY. Credit is pre-reserved, so R is never back-pressured while BUSY.
- outstanding-- on M_RVALID & M_RREADY & M_RLAST.
- credit++ on FIFO_POP in any state.
- Simultaneous events:
  - AR handshake + FIFO_POP: credit net change is -BURST_LEN+1.
  - AR handshake + RLAST: outstanding unchanged.
- credit saturates at FIFO_DEPTH; a pop at full credit is ignored.
- FRAME_START while BUSY: ignored, OVERRUN set (sticky until the next accepted frame start or reset).
- Credit and outstanding counters are sized to hold FIFO_DEPTH and MAX_OUTSTANDING without overflow.

Optional Feature:
- HDMI_FETCH_PERF_EN defined: PERF_STALL counts cycles in ISSUE where either (M_ARVALID & !M_ARREADY) or (remaining!=0 & !M_ARVALID & credit<BURST_LEN).
  - Counter saturates at 2^32-1.
  - Cleared on each accepted FRAME_START.
- Undefined: PERF_STALL is tied to 0 and no counter logic is built.

Test Plan:
- Basic frame: BASE_ADDR=0x1000_0000, FRAME_BURSTS=3, M_ARREADY=1, defaults, pops keep pace -> ARADDR 0x1000_0000, 0x1000_0400, 0x1000_0800 with ARLEN=15. After the third RLAST, DONE pulses once; BUSY drops the same cycle.
- Credit throttle: FRAME_BURSTS=20, no FIFO_POP -> exactly 16 bursts issued (credit 0), ARVALID stays low. Then 16 pops -> a 17th burst issues.
- Outstanding cap: FRAME_BURSTS=8, RVALID held low -> 4 AR handshakes then stall. One RLAST beat -> a 5th burst issues.
- AR stability and abort: ARREADY=0 with ARVALID=1, drop EN -> ARVALID/ARADDR held. Then ARREADY=1 for 1 cycle -> handshake, no further ARs. DONE pulses after outstanding reaches 0.
- Overrun and edge cases: FRAME_START mid-frame -> OVERRUN=1, address sequence unchanged. FRAME_BURSTS=0 in IDLE -> DONE pulse, no AR. BASE_ADDR=0x1000_0123 -> first ARADDR 0x1000_0000.
- Simultaneous events and perf (HDMI_FETCH_PERF_EN): AR handshake + FIFO_POP in the same cycle -> credit decreases by exactly 15. ARREADY withheld 10 cycles -> PERF_STALL=10. The next FRAME_START clears it to 0.

Source files
------------

// File: rtl/hdmi_scanout_fetch.sv
// Frame-buffer scanout read scheduler: issues credit- and outstanding-limited AXI AR bursts per frame.
// Define HDMI_FETCH_PERF_EN to build the PERF_STALL stall-cycle counter; otherwise PERF_STALL reads 0.
//
// state  | meaning
// IDLE   | waiting for an accepted FRAME_START
// ISSUE  | issuing AR bursts while credit, outstanding cap and EN allow
// DRAIN  | no more bursts; waiting for every outstanding burst's RLAST
module hdmi_scanout_fetch #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int BURST_LEN          = 16,
   parameter int MAX_OUTSTANDING    = 4,
   parameter int FIFO_DEPTH         = 256
) (
   input  logic                          ACLK,
   input  logic                          RST,
   input  logic                          EN,
   input  logic                          FRAME_START,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [15:0]                   FRAME_BURSTS,
   input  logic                          FIFO_POP,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
   output logic [7:0]                    M_ARLEN,
   output logic                          M_ARVALID,
   input  logic                          M_ARREADY,
   input  logic                          M_RVALID,
   input  logic                          M_RLAST,
   output logic                          M_RREADY,
   output logic                          BUSY,
   output logic                          DONE,
   output logic                          OVERRUN,
   output logic [31:0]                   PERF_STALL
);

   localparam int AW             = C_M_AXI_ADDR_WIDTH;
   localparam int BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
   localparam int BURST_BYTES    = BURST_LEN * BYTES_PER_BEAT;
   localparam int ALIGN_BITS     = $clog2(BURST_BYTES);
   localparam int CW             = $clog2(FIFO_DEPTH + 1);
   localparam int OW             = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << ALIGN_BITS;
   localparam logic [AW-1:0] BURST_INC  = AW'(BURST_BYTES);
   localparam logic [CW-1:0] BL_C       = CW'(BURST_LEN);
   localparam logic [CW:0]   DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
   localparam logic [OW-1:0] MAX_C      = OW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t          state, state_nxt;
   logic            ar_valid, ar_valid_nxt;
   logic            done, done_nxt;
   logic [AW-1:0]   ar_addr;
   logic [CW-1:0]   credit;
   logic [OW-1:0]   outstanding;
   logic [15:0]     remaining;
   logic            overrun;

   logic            ar_hs;
   logic            r_last_hs;
   logic            frame_go;
   logic            frame_empty;
   logic [CW-1:0]   credit_after;
   logic [OW-1:0]   outstanding_after;
   logic [15:0]     remaining_after;
   logic [CW:0]     credit_sum;
   logic [CW-1:0]   credit_nxt;
   logic            issue_ok;

   assign ar_hs       = ar_valid & M_ARREADY;
   assign r_last_hs   = M_RVALID & M_RREADY & M_RLAST;
   assign frame_go    = (state == S_IDLE) & FRAME_START & EN & (FRAME_BURSTS != 16'd0);
   assign frame_empty = (state == S_IDLE) & FRAME_START & (FRAME_BURSTS == 16'd0);

   // Counter values once this cycle's AR handshake is applied; the next burst is judged on these
   assign credit_after      = ar_hs ? (credit - BL_C) : credit;
   assign outstanding_after = ar_hs ? (outstanding + OW'(1)) : outstanding;
   assign remaining_after   = ar_hs ? (remaining - 16'd1) : remaining;

   assign issue_ok = (credit_after >= BL_C) && (outstanding_after < MAX_C)
                     && (remaining_after != 16'd0) && EN;

   assign credit_sum = {1'b0, credit_after} + {{CW{1'b0}}, FIFO_POP};
   assign credit_nxt = (credit_sum > DEPTH_C) ? DEPTH_C[CW-1:0] : credit_sum[CW-1:0];

   always_ff @(posedge ACLK) begin
      if (RST) begin
         state    <= S_IDLE;
         ar_valid <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ar_valid <= ar_valid_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ar_valid_nxt = 1'b0;
      done_nxt     = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_go) state_nxt = S_ISSUE;
            done_nxt = frame_empty;
         end
         S_ISSUE: begin
            if (ar_hs && (remaining == 16'd1)) begin
               state_nxt = S_DRAIN;
            end else if (!EN && !ar_valid) begin
               state_nxt = S_DRAIN;
            end
            // A presented address is never withdrawn before it is accepted
            if (ar_valid && !M_ARREADY) begin
               ar_valid_nxt = 1'b1;
            end else if ((state_nxt == S_ISSUE) && issue_ok) begin
               ar_valid_nxt = 1'b1;
            end
         end
         S_DRAIN: begin
            if (outstanding == '0) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (RST) begin
         credit      <= DEPTH_C[CW-1:0];
         outstanding <= '0;
         remaining   <= 16'd0;
         ar_addr     <= '0;
         overrun     <= 1'b0;
      end else begin
         credit <= credit_nxt;
         if (r_last_hs && (outstanding_after != '0)) begin
            outstanding <= outstanding_after - OW'(1);
         end else begin
            outstanding <= outstanding_after;
         end
         remaining <= frame_go ? FRAME_BURSTS : remaining_after;
         if (frame_go) begin
            ar_addr <= BASE_ADDR & ALIGN_MASK;
         end else if (ar_hs) begin
            ar_addr <= ar_addr + BURST_INC;
         end
         if (frame_go) begin
            overrun <= 1'b0;
         end else if (FRAME_START && (state != S_IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef HDMI_FETCH_PERF_EN
   logic [31:0] perf_stall;
   logic        stall;

   assign stall = (state == S_ISSUE) &&
                  ((ar_valid && !M_ARREADY) ||
                   ((remaining != 16'd0) && !ar_valid && (credit < BL_C)));

   always_ff @(posedge ACLK) begin
      if (RST) begin
         perf_stall <= 32'd0;
      end else if (frame_go) begin
         perf_stall <= 32'd0;
      end else if (stall && (perf_stall != 32'hFFFF_FFFF)) begin
         perf_stall <= perf_stall + 32'd1;
      end
   end

   assign PERF_STALL = perf_stall;
`else
   assign PERF_STALL = 32'd0;
`endif

   assign M_ARADDR  = ar_addr;
   assign M_ARLEN   = 8'(BURST_LEN - 1);
   assign M_ARVALID = ar_valid;
   assign BUSY      = (state != S_IDLE);
   assign M_RREADY  = BUSY;
   assign DONE      = done;
   assign OVERRUN   = overrun;

endmodule
